// File: rtl/roce_stack_lookup_arbiter_pkg.sv
// Shared RoCE wrapper types: DMA descriptor returned by the address lookup table.
// The poison access code matches no permitted access, so handlers fail the request cleanly.
package roce_stack_lookup_arbiter_pkg;

    typedef struct packed {
        logic [63:0] paddr;
        logic [31:0] buflen;
        logic [31:0] rkey;
        logic [3:0]  accesdesc;
    } dma_req_t;

    localparam logic [3:0] ACCESSDESC_POISON = 4'hF;

    function automatic dma_req_t poison_desc();
        dma_req_t d;
        d           = '0;
        d.accesdesc = ACCESSDESC_POISON;
        return d;
    endfunction

endpackage

// File: rtl/roce_stack_rr_picker.sv
// Combinational round-robin pick: first valid requester at or after i_ptr, wrapping.
// Zero latency, no state; o_any low when no requester is valid.
module roce_stack_rr_picker #(
    parameter int N_REQ = 2,
    localparam int GW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_valid,
    input  logic [GW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [GW-1:0]    o_idx,
    output logic             o_any
);

    logic [GW-1:0] w_cand;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_cand   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = GW'((int'(i_ptr) + k) % N_REQ);
            if (!o_any && i_valid[w_cand]) begin
                o_any            = 1'b1;
                o_idx            = w_cand;
                o_onehot[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/roce_stack_lookup_arbiter.sv
// Shares one vaddr->paddr lookup port among N_REQ requesters, one lookup in flight, round-robin.
// Best case 3 cycles grant-to-response; full valid/ready on all sides, timeout returns a poison descriptor.
module roce_stack_lookup_arbiter
    import roce_stack_lookup_arbiter_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk_i,
    input  logic                    aresetn_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic [N_REQ-1:0][63:0]  req_vaddr_i,
    input  logic [N_REQ-1:0][15:0]  req_qpn_i,
    output logic [N_REQ-1:0]        resp_valid_o,
    input  logic [N_REQ-1:0]        resp_ready_i,
    output dma_req_t                resp_data_o,
    output logic                    m_lookup_valid_o,
    input  logic                    m_lookup_ready_i,
    output logic [63:0]             m_lookup_vaddr_o,
    output logic [15:0]             m_lookup_qpn_o,
    input  logic                    s_lookup_valid_i,
    output logic                    s_lookup_ready_o,
    input  dma_req_t                s_lookup_data_i,
    output logic                    timeout_o,
    output logic [15:0]             drop_cnt_o
);

    localparam int GW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DELIVER} arb_state_e;

    arb_state_e      r_state, w_state_nxt;
    logic [GW-1:0]   r_rr_ptr, r_grant;
    logic [63:0]     r_vaddr;
    logic [15:0]     r_qpn;
    dma_req_t        r_data;
    logic            r_stale, r_timeout;
    logic [TW-1:0]   r_timer;
    logic [15:0]     r_drop_cnt;

    logic [N_REQ-1:0] w_pick_oh;
    logic [GW-1:0]    w_pick_idx;
    logic             w_pick_any;
    logic             w_take_req, w_take_rsp, w_timeout, w_done, w_drop;

    roce_stack_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .i_valid  (req_valid_i),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) r_state <= ARB_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take_req  = 1'b0;
        w_take_rsp  = 1'b0;
        w_timeout   = 1'b0;
        w_done      = 1'b0;
        // A stale beat is accepted in any state; in WAIT it must not be taken as the answer.
        w_drop      = s_lookup_valid_i && r_stale;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_any) begin
                    w_take_req  = 1'b1;
                    w_state_nxt = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (m_lookup_ready_i) w_state_nxt = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (s_lookup_valid_i && !r_stale) begin
                    w_take_rsp  = 1'b1;
                    w_state_nxt = ARB_DELIVER;
                end else if (!s_lookup_valid_i && r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ARB_DELIVER;
                end
            end
            ARB_DELIVER: begin
                if (resp_ready_i[r_grant]) begin
                    w_done      = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_rr_ptr   <= '0;
            r_grant    <= '0;
            r_vaddr    <= '0;
            r_qpn      <= '0;
            r_data     <= '0;
            r_stale    <= 1'b0;
            r_timeout  <= 1'b0;
            r_timer    <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_take_req) begin
                r_vaddr <= req_vaddr_i[w_pick_idx];
                r_qpn   <= req_qpn_i[w_pick_idx];
                r_grant <= w_pick_idx;
            end
            if (w_take_rsp)     r_data <= s_lookup_data_i;
            else if (w_timeout) r_data <= poison_desc();
            r_timeout <= w_timeout;
            if (w_timeout)   r_stale <= 1'b1;
            else if (w_drop) r_stale <= 1'b0;
            if (r_state == ARB_WAIT && w_state_nxt == ARB_WAIT && !w_drop) r_timer <= r_timer + TW'(1);
            else                                                           r_timer <= '0;
            if (w_done) r_rr_ptr <= (r_grant == GW'(N_REQ - 1)) ? '0 : r_grant + GW'(1);
            if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    // Grant is gated by reset so nothing handshakes while the arbiter is held.
    assign req_ready_o      = (r_state == ARB_IDLE && aresetn_i) ? w_pick_oh : '0;
    assign m_lookup_valid_o = (r_state == ARB_ISSUE);
    assign m_lookup_vaddr_o = r_vaddr;
    assign m_lookup_qpn_o   = r_qpn;
    assign s_lookup_ready_o = (r_state == ARB_WAIT) || r_stale;
    assign resp_valid_o     = (r_state == ARB_DELIVER) ? (N_REQ'(1) << r_grant) : '0;
    assign resp_data_o      = r_data;
    assign timeout_o        = r_timeout;
    assign drop_cnt_o       = r_drop_cnt;

endmodule

// File: doc/roce_stack_lookup_arbiter.md
# roce_stack_lookup_arbiter

Round-robin arbiter that shares the single virtual-to-physical address lookup port of the RoCE wrapper between `N_REQ` request handler instances, for example one READ and one WRITE request handler. It serialises lookups with one in flight at a time. It routes each `dma_req_t` response back to the requester that issued it. A response timeout returns a poisoned descriptor so that no requester hangs.

## Interface
- `N_REQ`, default 2: number of requesters; must be ≥ 2.
- `TIMEOUT_CYCLES`, default 1024: number of WAIT cycles before a lookup is abandoned; must be ≥ 2.
- `clk_i` in 1: clock.
- `aresetn_i` in 1: reset, asynchronous, active-low.
- `req_valid_i` in `[N_REQ]`: lookup request from requester i.
- `req_ready_o` out `[N_REQ]`: request accepted (single-cycle grant).
- `req_vaddr_i` in `[N_REQ][64]`: virtual address.
- `req_qpn_i` in `[N_REQ][16]`: queue pair number.
- `resp_valid_o` out `[N_REQ]`: response for requester i.
- `resp_ready_i` in `[N_REQ]`: requester i takes the response.
- `resp_data_o` out `dma_req_t`: response payload, shared by all requesters.
- `m_lookup_valid_o` out 1: lookup request to the table.
- `m_lookup_ready_i` in 1: table accepts the request.
- `m_lookup_vaddr_o` out 64: virtual address to the table.
- `m_lookup_qpn_o` out 16: queue pair number to the table.
- `s_lookup_valid_i` in 1: table response valid.
- `s_lookup_ready_o` out 1: arbiter accepts the table response.
- `s_lookup_data_i` in `dma_req_t`: table response payload.
- `timeout_o` out 1: one-cycle pulse when a lookup is abandoned.
- `drop_cnt_o` out 16: count of discarded stale responses; saturates at 16'hFFFF.

## Operation
- FSM states: `ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT`, `ARB_DELIVER`.
- **ARB_IDLE**
  - Winner = first i with `req_valid_i[i]`, searching from `rr_ptr_q` upward and wrapping modulo `N_REQ`.
  - `req_ready_o[winner]` = 1 combinationally in the same cycle.
  - Capture vaddr, qpn and grant index; go to ISSUE.
  - With no valid request, stay in IDLE.
- **ARB_ISSUE**
  - `m_lookup_valid_o` = 1, with vaddr and qpn held stable from registers.
  - On `m_lookup_ready_i`, clear the timer and go to WAIT.
- **ARB_WAIT**
  - `s_lookup_ready_o` = 1. The timer increments every cycle.
  - On `s_lookup_valid_i` with `stale_q` = 0: capture `s_lookup_data_i` and go to DELIVER.
  - On `s_lookup_valid_i` with `stale_q` = 1: discard the beat, clear `stale_q`, increment `drop_cnt`, clear the timer, and stay in WAIT.
  - When the timer reaches `TIMEOUT_CYCLES`-1 with no accepted response:
    - capture the poison descriptor (paddr = 0, buflen = 0, rkey = 0, accesdesc = 4'hF);
    - pulse `timeout_o`, set `stale_q`, and go to DELIVER.
  - A valid response on the timeout cycle wins: it is captured and no timeout occurs.
- **ARB_DELIVER**
  - `resp_valid_o[grant]` = 1 and `resp_data_o` = the captured descriptor.
  - On `resp_ready_i[grant]`, set `rr_ptr` = (grant+1) mod `N_REQ` and go to IDLE.
  - `resp_ready_i` of non-granted requesters is ignored.
- **Outside WAIT**
  - `s_lookup_ready_o` = `stale_q`.
  - A beat taken there is discarded, clears `stale_q`, and increments `drop_cnt`.
- **Poison descriptor:** accesdesc 4'hF matches no permitted access code, so the request handler flags an error and completes normally.

## Timing
- Reset values:
  - FSM = IDLE, `rr_ptr` = 0, `stale_q` = 0, timer = 0, `drop_cnt` = 0;
  - all valid and ready outputs = 0;
  - `m_lookup_vaddr_o`, `m_lookup_qpn_o` and `resp_data_o` = 0.
- Reset mid-operation abandons the in-flight lookup. `stale_q` is not set.
- Minimum latency from request accepted to response valid: 3 cycles, when the table returns in the cycle after accept.
  - cycle 0: IDLE grant
  - cycle 1: ISSUE with ready
  - cycle 2: WAIT with valid
  - cycle 3: DELIVER
- Throughput: one lookup per 4 cycles at best.
- `req_ready_o` is one-hot or zero, and is high only in IDLE.
- No output except `req_ready_o` and `s_lookup_ready_o` depends combinationally on inputs.
- Timer width is `$clog2(TIMEOUT_CYCLES)`; it does not wrap, because it is cleared on leaving WAIT.
- Grant index width is `$clog2(N_REQ)`.

## Structure
- `dma_req_t` and the constant `ACCESSDESC_POISON` = 4'hF live in the shared RoCE wrapper package.
- The FSM state enum is local to the module.
- One sub-module, `roce_stack_rr_picker`: combinational round-robin winner from the valid vector and `rr_ptr`, outputting one-hot plus index.

## Test plan
- **Single requester:** `req_valid_i`[0] with vaddr 0x1000, qpn 5; table ready immediately and returns paddr 0x8000_0000 one cycle later → `m_lookup_vaddr_o` = 0x1000, `resp_valid_o`[0] high 3 cycles after accept with paddr 0x8000_0000; `resp_valid_o`[1] stays 0.
- **Fairness:** both requesters valid continuously for 6 lookups → grant order 0,1,0,1,0,1; each response is routed to its own requester.
- **Backpressure:** `m_lookup_ready_i` low for 5 cycles, then `resp_ready_i` low for 4 cycles → vaddr and qpn stay stable during ISSUE; `resp_valid_o` and data stay stable until taken; no new grant is issued meanwhile.
- **Timeout:** `TIMEOUT_CYCLES` = 8 and the table never responds → `timeout_o` pulses on the 8th WAIT cycle and the requester receives accesdesc 4'hF. A late response 3 cycles later is dropped: `drop_cnt_o` = 1 and it is not delivered.
- **Boundary:** a response arriving exactly on cycle `TIMEOUT_CYCLES`-1 → it is delivered normally; no `timeout_o`; `stale_q` stays 0.
- **Reset mid-WAIT:** deassert `aresetn_i` during WAIT → all outputs return to 0 asynchronously; after release, a new request from requester 0 is granted first.
